// File: rtl/fir_decim_fifo.sv
// -----------------------------------------------------------------------------
// fir_decim_fifo
//   Decimates the filtered sample stream from fir_sync by keeping one of every
//   DECIM accepted samples. Kept samples are buffered in a first-word
//   fall-through FIFO for a downstream consumer.
//
// Handshake: a sample enters when din_valid && en at a rising edge. Only
// samples that land on phase 0 are written to the FIFO. On the output side,
// a word leaves the FIFO at a rising edge where dout_valid && dout_ready are
// both high. dout_valid depends only on registered state, never on
// dout_ready.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   din         signed sample, DW bits
//   din_valid   din carries a new sample this cycle
//   en          decimator enable; low freezes the phase and blocks writes
//   dout        head of the FIFO, or 0 when the FIFO is empty
//   dout_valid  FIFO is not empty
//   dout_ready  consumer takes dout this cycle
//   count       occupancy, 0..DEPTH
//   full        count == DEPTH
//   overflow    sticky; set when a kept sample is lost because the FIFO is full
//   clr_ovf     synchronous clear of overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module fir_decim_fifo #(
   parameter int DW    = 11,
   parameter int DECIM = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DW-1:0]            din,
   input  logic                     din_valid,
   input  logic                     en,
   output logic [DW-1:0]            dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // A one-bit phase register is kept even for DECIM == 1. It never leaves 0.
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [PW-1:0] phase;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [DW-1:0] mem [DEPTH];

   logic accept;
   logic keep;
   logic pop;
   logic push;
   logic drop;

   assign dout_valid = (count != '0);
   assign full       = (count == CNT_FULL);

   // First-word fall-through: the head is always visible. It is forced to 0
   // when the FIFO is empty so that stale memory is never shown.
   assign dout = dout_valid ? mem[rd_ptr] : '0;

   assign accept = din_valid && en;
   assign keep   = accept && (phase == '0);
   assign pop    = dout_valid && dout_ready;
   // When the FIFO is full, a pop on the same edge frees the slot for the
   // push. Pointers move together and count stays at DEPTH.
   assign push   = keep && (!full || pop);
   assign drop   = keep && full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A drop on the same edge as clr_ovf must leave the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   // Storage is not reset. Its contents are hidden by the dout gating while
   // the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule
